spi_slave_regif: RTL

//  3-wire SPI responder (CSB/SCLK/SDIO) for the ADC configuration port protocol.

---
 rtl/spi_slave_regif.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_regif.sv
// 3-wire SPI responder for the ADC configuration port: oversamples CSB/SCLK/SDIO in the
// clk domain and turns 24-bit frames into one-cycle register-file read/write strobes.
module spi_slave_regif #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csb_i,
  input  logic        sclk_i,
  input  logic        sdio_i,
  output logic        sdio_o,
  output logic        sdio_oe,
  output logic [12:0] reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        abort
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD_FETCH,
    S_RD_LATCH,
    S_RD_SHIFT,
    S_WR_DATA,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] csb_sync, sclk_sync, sdio_sync;
  logic csb_q, sdio_q, sclk_rise, sclk_fall;

  // Chains reset to 0 so that a CSB held low through reset never looks like a fresh
  // frame start: the FSM waits in DONE until CSB is genuinely seen high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      csb_sync  <= '0;
      sclk_sync <= '0;
      sdio_sync <= '0;
    end else begin
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_i};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], sdio_i};
    end
  end

  assign csb_q     = csb_sync[SYNC_STAGES-1];
  assign sdio_q    = sdio_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_sync[SYNC_STAGES-2] & ~sclk_sync[SYNC_STAGES-1];
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-2] & sclk_sync[SYNC_STAGES-1];

  logic [4:0]  cnt_q;
  logic        rw_q;
  logic [11:0] addr_sr;
  logic [6:0]  dat_sr;
  logic [7:0]  tx_sr;
  logic        oe_q;
  logic [12:0] addr_next;
  logic [7:0]  dat_next;

  assign addr_next = {addr_sr, sdio_q};
  assign dat_next  = {dat_sr, sdio_q};

  logic cnt_clr, cnt_inc, hdr_shift, hdr_done, dat_shift, wr_fire;
  logic rd_load, tx_drive, tx_stop, abort_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_DONE;
    else     state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    hdr_shift = 1'b0;
    hdr_done  = 1'b0;
    dat_shift = 1'b0;
    wr_fire   = 1'b0;
    rd_load   = 1'b0;
    tx_drive  = 1'b0;
    tx_stop   = 1'b0;
    abort_d   = 1'b0;
    reg_re    = 1'b0;
    if (csb_q) begin
      state_d = S_IDLE;
      abort_d = state_q inside {S_HDR, S_RD_FETCH, S_RD_LATCH, S_RD_SHIFT, S_WR_DATA};
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_clr = 1'b1;
          state_d = S_HDR;
        end
        S_HDR: begin
          if (sclk_rise) begin
            cnt_inc   = 1'b1;
            hdr_shift = 1'b1;
            if (cnt_q == 5'd15) begin
              hdr_done = 1'b1;
              state_d  = rw_q ? S_RD_FETCH : S_WR_DATA;
            end
          end
        end
        S_RD_FETCH: begin
          reg_re  = 1'b1;
          cnt_inc = sclk_rise;
          state_d = S_RD_LATCH;
        end
        S_RD_LATCH: begin
          rd_load = 1'b1;
          cnt_inc = sclk_rise;
          state_d = S_RD_SHIFT;
        end
        S_RD_SHIFT: begin
          cnt_inc = sclk_rise;
          if (sclk_fall) begin
            if (cnt_q >= 5'd24) begin
              tx_stop = 1'b1;
              state_d = S_DONE;
            end else begin
              tx_drive = 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (sclk_rise) begin
            cnt_inc   = 1'b1;
            dat_shift = 1'b1;
            if (cnt_q == 5'd23) begin
              wr_fire = 1'b1;
              state_d = S_DONE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      addr_sr   <= '0;
      dat_sr    <= '0;
      tx_sr     <= '0;
      oe_q      <= 1'b0;
      sdio_o    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_we    <= 1'b0;
      abort     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= wr_fire;
      abort  <= abort_d;
      busy   <= ~csb_q;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 5'd1;
      if (hdr_shift) begin
        addr_sr <= addr_next[11:0];
        if (cnt_q == 5'd0) rw_q <= sdio_q;
      end
      if (hdr_done)  reg_addr  <= addr_next;
      if (dat_shift) dat_sr    <= dat_next[6:0];
      if (wr_fire)   reg_wdata <= dat_next;
      if (rd_load)   tx_sr     <= reg_rdata;
      if (tx_drive) begin
        sdio_o <= tx_sr[7];
        tx_sr  <= {tx_sr[6:0], 1'b0};
        oe_q   <= 1'b1;
      end
      if (tx_stop || csb_q) oe_q <= 1'b0;
    end
  end

  // Gated by CSB directly so the pad is released in the same cycle CSB is seen high.
  assign sdio_oe = oe_q & ~csb_q;

endmodule
